// File: rtl/ccip_mem_responder.sv
// ccip_mem_responder: stand-in host memory for CCI-P channels c0 (read) and c1 (write).
// AFU requests are queued per channel and serviced from an internal 512-bit line memory.
// Read data travels through an RD_LAT-deep pipeline; writes are acknowledged one cycle
// after they leave their queue. A write and a read leaving in the same cycle to the same
// line return the freshly written data.
// Optional build macro CCIP_MEM_RSP_STATS_EN adds rd_rsp_count / wr_rsp_count outputs.
module ccip_mem_responder #(
    parameter int ADDR_W         = 6,
    parameter int RD_LAT         = 4,
    parameter int FIFO_DEPTH     = 8,
    parameter int ALMFULL_THRESH = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         c0_req_valid,
    input  logic [41:0]  c0_req_addr,
    input  logic [15:0]  c0_req_mdata,
    input  logic         c1_req_valid,
    input  logic [41:0]  c1_req_addr,
    input  logic [15:0]  c1_req_mdata,
    input  logic [511:0] c1_req_data,
    input  logic         mem_stall,
    output logic         c0_tx_alm_full,
    output logic         c1_tx_alm_full,
    output logic         c0_rsp_valid,
    output logic [3:0]   c0_rsp_type,
    output logic [15:0]  c0_rsp_mdata,
    output logic [511:0] c0_rsp_data,
    output logic         c1_rsp_valid,
    output logic [3:0]   c1_rsp_type,
    output logic [15:0]  c1_rsp_mdata,
    output logic         err_overflow,
    output logic         err_oob
`ifdef CCIP_MEM_RSP_STATS_EN
    ,
    output logic [31:0]  rd_rsp_count,
    output logic [31:0]  wr_rsp_count
`endif
);

    localparam int PW    = $clog2(FIFO_DEPTH) + 1;
    localparam int IW    = PW - 1;
    localparam int LINES = 1 << ADDR_W;

    logic [41:0]   rdAddrFifo_q  [FIFO_DEPTH];
    logic [15:0]   rdMdataFifo_q [FIFO_DEPTH];
    logic [41:0]   wrAddrFifo_q  [FIFO_DEPTH];
    logic [15:0]   wrMdataFifo_q [FIFO_DEPTH];
    logic [511:0]  wrDataFifo_q  [FIFO_DEPTH];
    logic [511:0]  mem_q         [LINES];

    logic [PW-1:0] rdWptr_q, rdWptr_d, rdRptr_q, rdRptr_d;
    logic [PW-1:0] wrWptr_q, wrWptr_d, wrRptr_q, wrRptr_d;
    logic [PW-1:0] rdCount_d, wrCount_d;
    logic          rdFull, rdEmpty, rdPush, rdPop;
    logic          wrFull, wrEmpty, wrPush, wrPop;
    logic [41:0]   rdPopAddr, wrPopAddr;
    logic [15:0]   rdPopMdata, wrPopMdata;
    logic [511:0]  wrPopData, rdLineData;
    logic          rdInRange, wrInRange;

    logic          rdAlmFull_q, wrAlmFull_q;
    logic          errOverflow_q, errOob_q;
    logic          wrRspValid_q;
    logic [15:0]   wrRspMdata_q;
    logic          rdPipeValid_q [RD_LAT];
    logic [15:0]   rdPipeMdata_q [RD_LAT];
    logic [511:0]  rdPipeData_q  [RD_LAT];

    // Queue status, push/pop decisions, next pointers and the line returned to a popped read.
    always_comb begin
        rdEmpty    = (rdWptr_q == rdRptr_q);
        wrEmpty    = (wrWptr_q == wrRptr_q);
        rdFull     = (rdWptr_q == {~rdRptr_q[PW-1], rdRptr_q[IW-1:0]});
        wrFull     = (wrWptr_q == {~wrRptr_q[PW-1], wrRptr_q[IW-1:0]});
        rdPush     = c0_req_valid && !rdFull;
        wrPush     = c1_req_valid && !wrFull;
        rdPop      = !rdEmpty && !mem_stall && !reset;
        wrPop      = !wrEmpty && !mem_stall && !reset;
        rdWptr_d   = rdWptr_q + PW'(rdPush);
        rdRptr_d   = rdRptr_q + PW'(rdPop);
        wrWptr_d   = wrWptr_q + PW'(wrPush);
        wrRptr_d   = wrRptr_q + PW'(wrPop);
        rdCount_d  = rdWptr_d - rdRptr_d;
        wrCount_d  = wrWptr_d - wrRptr_d;
        rdPopAddr  = rdAddrFifo_q[rdRptr_q[IW-1:0]];
        rdPopMdata = rdMdataFifo_q[rdRptr_q[IW-1:0]];
        wrPopAddr  = wrAddrFifo_q[wrRptr_q[IW-1:0]];
        wrPopMdata = wrMdataFifo_q[wrRptr_q[IW-1:0]];
        wrPopData  = wrDataFifo_q[wrRptr_q[IW-1:0]];
        rdInRange  = (rdPopAddr[41:ADDR_W] == '0);
        wrInRange  = (wrPopAddr[41:ADDR_W] == '0);
        rdLineData = '0;
        if (rdPop && rdInRange) begin
            if (wrPop && wrInRange && (wrPopAddr == rdPopAddr)) begin
                rdLineData = wrPopData;
            end else begin
                rdLineData = mem_q[rdPopAddr[ADDR_W-1:0]];
            end
        end
    end

    // Request queue storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (rdPush) begin
            rdAddrFifo_q[rdWptr_q[IW-1:0]]  <= c0_req_addr;
            rdMdataFifo_q[rdWptr_q[IW-1:0]] <= c0_req_mdata;
        end
        if (wrPush) begin
            wrAddrFifo_q[wrWptr_q[IW-1:0]]  <= c1_req_addr;
            wrMdataFifo_q[wrWptr_q[IW-1:0]] <= c1_req_mdata;
            wrDataFifo_q[wrWptr_q[IW-1:0]]  <= c1_req_data;
        end
    end

    // Line memory commit for in-range writes leaving the write queue.
    always_ff @(posedge clk) begin
        if (wrPop && wrInRange) begin
            mem_q[wrPopAddr[ADDR_W-1:0]] <= wrPopData;
        end
    end

    // Pointers, flags, write acknowledge and the read delivery pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdWptr_q      <= '0;
            rdRptr_q      <= '0;
            wrWptr_q      <= '0;
            wrRptr_q      <= '0;
            rdAlmFull_q   <= 1'b0;
            wrAlmFull_q   <= 1'b0;
            errOverflow_q <= 1'b0;
            errOob_q      <= 1'b0;
            wrRspValid_q  <= 1'b0;
            wrRspMdata_q  <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                rdPipeValid_q[i] <= 1'b0;
                rdPipeMdata_q[i] <= '0;
                rdPipeData_q[i]  <= '0;
            end
        end else begin
            rdWptr_q      <= rdWptr_d;
            rdRptr_q      <= rdRptr_d;
            wrWptr_q      <= wrWptr_d;
            wrRptr_q      <= wrRptr_d;
            rdAlmFull_q   <= (rdCount_d >= PW'(ALMFULL_THRESH));
            wrAlmFull_q   <= (wrCount_d >= PW'(ALMFULL_THRESH));
            errOverflow_q <= errOverflow_q | (c0_req_valid && rdFull) | (c1_req_valid && wrFull);
            errOob_q      <= errOob_q | (rdPop && !rdInRange) | (wrPop && !wrInRange);
            wrRspValid_q  <= wrPop;
            wrRspMdata_q  <= wrPop ? wrPopMdata : '0;
            rdPipeValid_q[0] <= rdPop;
            rdPipeMdata_q[0] <= rdPop ? rdPopMdata : '0;
            rdPipeData_q[0]  <= rdLineData;
            for (int i = 1; i < RD_LAT; i++) begin
                rdPipeValid_q[i] <= rdPipeValid_q[i-1];
                rdPipeMdata_q[i] <= rdPipeMdata_q[i-1];
                rdPipeData_q[i]  <= rdPipeData_q[i-1];
            end
        end
    end

    assign c0_tx_alm_full = rdAlmFull_q;
    assign c1_tx_alm_full = wrAlmFull_q;
    assign c0_rsp_valid   = rdPipeValid_q[RD_LAT-1];
    assign c0_rsp_type    = 4'h0;
    assign c0_rsp_mdata   = rdPipeMdata_q[RD_LAT-1];
    assign c0_rsp_data    = rdPipeData_q[RD_LAT-1];
    assign c1_rsp_valid   = wrRspValid_q;
    assign c1_rsp_type    = 4'h0;
    assign c1_rsp_mdata   = wrRspMdata_q;
    assign err_overflow   = errOverflow_q;
    assign err_oob        = errOob_q;

`ifdef CCIP_MEM_RSP_STATS_EN
    logic [31:0] rdRspCount_q, wrRspCount_q;

    // Count delivered responses per channel, wrapping naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdRspCount_q <= '0;
            wrRspCount_q <= '0;
        end else begin
            if (c0_rsp_valid) rdRspCount_q <= rdRspCount_q + 32'd1;
            if (c1_rsp_valid) wrRspCount_q <= wrRspCount_q + 32'd1;
        end
    end

    assign rd_rsp_count = rdRspCount_q;
    assign wr_rsp_count = wrRspCount_q;
`else
    // No response statistics hardware in this build.
`endif

endmodule

// File: doc/ccip_mem_responder.md
Name: ccip_mem_responder

Overview:
Host-side memory endpoint for CCI-P channels c0 (read) and c1 (write). Stands in for the FIU/host memory when an AFU block is simulated or emulated standalone. It queues AFU read and write requests and services them from an internal line-wide memory. It returns eRSP_RDLINE / eRSP_WRLINE responses with the original mdata and drives c0TxAlmFull / c1TxAlmFull back-pressure.

Parameters:
ADDR_W, 6, memory index width; memory holds 2**ADDR_W 512-bit lines
RD_LAT, 4, cycles from read pop to c0_rsp_valid; range 1..8
FIFO_DEPTH, 8, entries in each request queue; power of 2
ALMFULL_THRESH, 5, occupancy at or above which the almost-full flag asserts; must be <= FIFO_DEPTH-3

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
c0_req_valid  in  1  read request
c0_req_addr  in  42  cache-line address
c0_req_mdata  in  16  request tag
c1_req_valid  in  1  write request
c1_req_addr  in  42  cache-line address
c1_req_mdata  in  16  request tag
c1_req_data  in  512  write data
mem_stall  in  1  test hook; while high, neither queue pops
c0_tx_alm_full  out  1  read queue almost full
c1_tx_alm_full  out  1  write queue almost full
c0_rsp_valid  out  1  read response
c0_rsp_type  out  4  4'h0 = eRSP_RDLINE
c0_rsp_mdata  out  16  echoed tag
c0_rsp_data  out  512  line data
c1_rsp_valid  out  1  write response
c1_rsp_type  out  4  4'h0 = eRSP_WRLINE
c1_rsp_mdata  out  16  echoed tag
err_overflow  out  1  sticky; a request arrived while its queue was full
err_oob  out  1  sticky; address bits [41:ADDR_W] were non-zero

Behaviour:
- Reset: all outputs are 0; both queues and the read pipeline are emptied; err flags are cleared. Memory contents are not reset (undefined until written).
- Reset mid-operation: in-flight reads and writes are discarded and no responses are emitted for them. Writes already committed stay in memory.
- Enqueue: a request is pushed in the cycle its valid is sampled high, provided its queue is not full.
- Queue full: the request is dropped with no response, and err_overflow is set.
- Pop: each queue pops at most one entry per cycle, when non-empty and mem_stall=0. The two queues are independent.
- Write pop: if the address is in range, the memory line is written. c1_rsp_valid pulses exactly 1 cycle after the pop, with the popped mdata.
- Read pop: memory is read and the result is delivered through an RD_LAT-deep shift pipeline. c0_rsp_valid pulses RD_LAT cycles after the pop.
- Idle latency: with queue empty and no stall, a read sampled at edge N pops at N+1, so c0_rsp_valid is high in cycle N+1+RD_LAT. A write sampled at edge N gives c1_rsp_valid in cycle N+2.
- Same-cycle write pop and read pop to the same line: the write is committed first, and the read returns the new data (bypass).
- Out-of-range address: a read returns all-zero data with a normal response; a write is not committed but is still acknowledged. err_oob is set in both cases.
- Almost-full: registered; cX_tx_alm_full = (occupancy >= ALMFULL_THRESH), evaluated after this cycle's push/pop. The 3-entry slack absorbs requester registering delay.
- Responses have no back-pressure. Both channels may respond in the same cycle.
- Ordering: responses on each channel are in request order. There is no cross-channel ordering beyond the bypass rule above.
- Queue pointers: ADDR width log2(FIFO_DEPTH)+1 with a wrap bit. Full = pointers equal except the MSB; empty = pointers fully equal.

Optional Feature:
CCIP_MEM_RSP_STATS_EN
- Defined: adds outputs rd_rsp_count [31:0] and wr_rsp_count [31:0].
  - Each increments on every cX_rsp_valid and wraps 0xFFFFFFFF to 0.
  - Both clear on reset.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Write-then-read, idle: write addr 0x3, mdata 0x11, data 512'hA5...A5 at cycle 0. Then c1_rsp_valid at cycle 2 with mdata 0x11. Read addr 0x3, mdata 0x22 at cycle 4. Then c0_rsp_valid at cycle 9 (RD_LAT=4) with data 512'hA5...A5, mdata 0x22, type 0.
- Back-pressure: mem_stall=1, then issue 5 reads. c0_tx_alm_full rises the cycle after the 5th push. Push 3 more: no error. A 9th push sets err_overflow and gets no response. Release the stall: exactly 8 responses, in mdata order.
- Bypass: preload line 7 = 0. Write 1 to line 7 and read line 7 so both pop in the same cycle. The read returns 1.
- Out-of-range: read addr 0x40 (ADDR_W=6). Returns data 0 and sets err_oob. A write to 0x40 is acknowledged, and line 0 is unchanged.
- Reset mid-flight: 3 reads in the pipeline, then assert reset for 1 cycle. No c0_rsp_valid follows, alm_full=0, err flags=0.
- Stats (macro defined): 4 reads and 2 writes, then rd_rsp_count=4 and wr_rsp_count=2. Force the counter to 0xFFFFFFFF; one more read wraps it to 0.
